inv_cipher_ctrl: RTL

Round sequencer for the AES-128 inverse cipher. It accepts one 128-bit ciphertext block per transaction and holds the working state. It performs AddRoundKey internally and time-shares a single external operation bus among the registered InvShiftRows, InvSubBytes and InvMixColumns units. It returns the plaintext over a valid/ready handshake. It sits between the block-level input/output interfaces and the inverse round datapath, and requests round keys from the key store by index.

---
 rtl/inv_cipher_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/inv_cipher_ctrl.sv
// inv_cipher_ctrl: round sequencer for the AES-128 inverse cipher.
// Holds the working state, performs AddRoundKey internally and time-shares one
// external operation bus among the InvShiftRows, InvSubBytes and InvMixColumns units.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    ciphertext handshake, data_in carries the block
//   out_valid/out_ready  plaintext handshake, data_out is the working state
//   rk_idx/rk            round-key request index and combinational key return
//   op_sel/op_en         unit select (01 ISR, 10 ISB, 11 IMC) and launch strobe
//   op_state/op_result   unit operand (working state) and result (1 cycle later)
//   busy                 a block is in flight or waiting for output
module inv_cipher_ctrl #(
   parameter int unsigned WORD_SIZE  = 8,
   parameter int unsigned ARRAY_SIZE = 16,
   parameter int unsigned NR         = 10
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [WORD_SIZE*ARRAY_SIZE-1:0]  data_in,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [WORD_SIZE*ARRAY_SIZE-1:0]  data_out,
   output logic [3:0]                       rk_idx,
   input  logic [WORD_SIZE*ARRAY_SIZE-1:0]  rk,
   output logic [1:0]                       op_sel,
   output logic                             op_en,
   output logic [WORD_SIZE*ARRAY_SIZE-1:0]  op_state,
   input  logic [WORD_SIZE*ARRAY_SIZE-1:0]  op_result,
   output logic                             busy
);

   localparam int unsigned StW   = WORD_SIZE * ARRAY_SIZE;
   localparam logic [3:0]  NrIdx = 4'(NR);

   typedef enum logic [3:0] {
      StIdle,
      StIsrGo,
      StIsrCap,
      StIsbGo,
      StIsbCap,
      StArk,
      StImcGo,
      StImcCap,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [StW-1:0]   st_q, st_d;
   logic [3:0]       rnd_q, rnd_d;
   logic [1:0]       op_sel_q;

   assign data_out = st_q;
   assign op_state = st_q;

   always_comb begin
      state_d   = state_q;
      st_d      = st_q;
      rnd_d     = rnd_q;
      op_sel    = op_sel_q;   // select holds its last value between launches
      op_en     = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      rk_idx    = 4'd0;
      busy      = 1'b1;
      case (state_q)
         StIdle: begin
            // in_ready is masked by rst so a same-cycle in_valid is never seen as accepted
            in_ready = ~rst;
            rk_idx   = NrIdx;
            busy     = 1'b0;
            if (in_valid) begin
               st_d    = data_in ^ rk;
               rnd_d   = NrIdx - 4'd1;
               state_d = StIsrGo;
            end
         end
         StIsrGo: begin
            op_sel  = 2'b01;
            op_en   = 1'b1;
            state_d = StIsrCap;
         end
         StIsrCap: begin
            st_d    = op_result;
            state_d = StIsbGo;
         end
         StIsbGo: begin
            op_sel  = 2'b10;
            op_en   = 1'b1;
            state_d = StIsbCap;
         end
         StIsbCap: begin
            st_d    = op_result;
            state_d = StArk;
         end
         StArk: begin
            rk_idx  = rnd_q;
            st_d    = st_q ^ rk;
            // the last round skips InvMixColumns; rnd is never decremented past 0
            state_d = (rnd_q == 4'd0) ? StDone : StImcGo;
         end
         StImcGo: begin
            op_sel  = 2'b11;
            op_en   = 1'b1;
            state_d = StImcCap;
         end
         StImcCap: begin
            st_d    = op_result;
            rnd_d   = rnd_q - 4'd1;
            state_d = StIsrGo;
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         st_q     <= '0;
         rnd_q    <= 4'd0;
         op_sel_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         st_q     <= st_d;
         rnd_q    <= rnd_d;
         op_sel_q <= op_sel;
      end
   end

endmodule
